i2c_scl_clkgen: RTL and testbench

- Open-drain SCL timing generator directly upstream of fmc_i2c_controller on the FMC424 I2C bus.
- The controller holds it idle via clkgen_rst. When released, the block drives SCL through the IOBUF T pin.
- It gives the controller single-cycle phase ticks: where to change SDA, where to sample SDA, and the SCL edges.
- It honours slave clock stretching by waiting for the synchronized pin to read high.

---
 rtl/i2c_pkg.sv | 20 ++
 rtl/i2c_sync2.sv | 14 +
 rtl/i2c_scl_clkgen.sv | 100 ++++++++++
 tb/tb_i2c_scl_clkgen.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared I2C state encoding, default bus timing constants and the quarter-period helper.
package i2c_pkg;
    localparam int DEF_CLK_FREQ_HZ         = 100_000_000;
    localparam int DEF_SCL_FREQ_HZ         = 100_000;
    localparam int DEF_STRETCH_TIMEOUT_CYC = 1_000_000;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        LOW_A,
        LOW_B,
        WAIT_HIGH,
        HIGH_A,
        HIGH_B
    } scl_state_t;

    function automatic int quarter_cycles(input int clk_hz, input int scl_hz);
        return clk_hz / (4 * scl_hz);
    endfunction
endpackage

// File: rtl/i2c_sync2.sv
// i2c_sync2: 2-FF synchronizer for an open-drain bus line; resets to 1 (bus idle high).
module i2c_sync2 (
    input  logic CLK,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge CLK) begin
        if (reset) {q, meta} <= 2'b11;
        else {q, meta} <= {meta, d};
    end
endmodule

// File: rtl/i2c_scl_clkgen.sv
// i2c_scl_clkgen: open-drain SCL generator with phase ticks and slave clock-stretch support.
// Define I2C_STRETCH_TIMEOUT_EN to abort a stretch longer than STRETCH_TIMEOUT_CYC cycles.
module i2c_scl_clkgen
    import i2c_pkg::*;
#(
    parameter int CLK_FREQ_HZ         = DEF_CLK_FREQ_HZ,
    parameter int SCL_FREQ_HZ         = DEF_SCL_FREQ_HZ,
    parameter int STRETCH_TIMEOUT_CYC = DEF_STRETCH_TIMEOUT_CYC
) (
    input  logic CLK,
    input  logic reset,
    input  logic clkgen_rst,
    input  logic scl_pin_val,
    output logic scl_t,
    output logic fall_tick,
    output logic data_tick,
    output logic rise_tick,
    output logic sample_tick,
    output logic stretching,
    output logic running,
    output logic stretch_timeout
);
    localparam int QUARTER = quarter_cycles(CLK_FREQ_HZ, SCL_FREQ_HZ);
    localparam int CW = QUARTER < 2 ? 1 : $clog2(QUARTER);
    localparam logic [CW-1:0] RELOAD = CW'(QUARTER - 1);

    if (QUARTER < 2 || STRETCH_TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("i2c_scl_clkgen: QUARTER must be >= 2 and STRETCH_TIMEOUT_CYC >= 1");
    end

    scl_state_t    state, nxt;
    logic [CW-1:0] cnt;
    logic          half, done, timeout, scl_sync;

    i2c_sync2 u_sync (.CLK(CLK), .reset(reset), .d(scl_pin_val), .q(scl_sync));

    assign done       = cnt == '0;
    assign stretching = state == WAIT_HIGH && !scl_sync;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:      nxt = stretch_timeout ? IDLE : HOLD;
            HOLD:      nxt = done && half ? LOW_A : HOLD;
            LOW_A:     nxt = done ? LOW_B : LOW_A;
            LOW_B:     nxt = done ? WAIT_HIGH : LOW_B;
            WAIT_HIGH: nxt = timeout ? IDLE : scl_sync ? HIGH_A : WAIT_HIGH;
            HIGH_A:    nxt = done ? HIGH_B : HIGH_A;
            HIGH_B:    nxt = done ? LOW_A : HIGH_B;
            default:   nxt = IDLE;
        endcase
    end

    // HOLD spans two quarters; half marks the second so the counter stays QUARTER wide.
    always_ff @(posedge CLK) begin
        if (reset || clkgen_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            half        <= 1'b0;
            scl_t       <= 1'b1;
            fall_tick   <= 1'b0;
            data_tick   <= 1'b0;
            rise_tick   <= 1'b0;
            sample_tick <= 1'b0;
            running     <= 1'b0;
        end else begin
            state       <= nxt;
            half        <= state == HOLD && nxt == HOLD && (half || done);
            cnt         <= nxt == IDLE || nxt == WAIT_HIGH ? '0
                         : nxt != state || (state == HOLD && done) ? RELOAD
                         : cnt - 1'b1;
            scl_t       <= nxt != LOW_A && nxt != LOW_B;
            fall_tick   <= nxt == LOW_A && state != LOW_A;
            data_tick   <= nxt == LOW_B && state != LOW_B;
            rise_tick   <= nxt == HIGH_A && state != HIGH_A;
            sample_tick <= nxt == HIGH_B && state != HIGH_B;
            running     <= nxt != IDLE;
        end
    end

`ifdef I2C_STRETCH_TIMEOUT_EN
    localparam int SW = $clog2(STRETCH_TIMEOUT_CYC + 1);
    logic [SW-1:0] scnt;

    assign timeout = state == WAIT_HIGH && !scl_sync && scnt == SW'(STRETCH_TIMEOUT_CYC - 1);

    always_ff @(posedge CLK) begin
        if (reset || clkgen_rst) begin
            scnt            <= '0;
            stretch_timeout <= 1'b0;
        end else begin
            scnt            <= state == WAIT_HIGH ? scnt + 1'b1 : '0;
            stretch_timeout <= stretch_timeout | timeout;
        end
    end
`else
    assign timeout         = 1'b0;
    assign stretch_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_i2c_scl_clkgen.sv
// tb_i2c_scl_clkgen: scoreboard bench; expected tick kinds and cycles are queued at stimulus time
// and matched against observed ticks on the falling clock edge.
module tb_i2c_scl_clkgen;
    localparam int Q  = 250;
    localparam int P  = 4 * Q + 3;
    localparam int FQ = 2;

    typedef struct {
        int kind;
        int cyc;
    } exp_t;

    logic CLK = 1'b0, reset = 1'b1, clkgen_rst = 1'b1, f_crst = 1'b1, hold_low = 1'b0;
    logic scl_pin_val, scl_t, fall_tick, data_tick, rise_tick, sample_tick;
    logic stretching, running, stretch_timeout;
    logic f_pin, f_scl_t, f_fall, f_data, f_rise, f_sample, f_str, f_run, f_to;
    int   cyc = 0, checks = 0, errors = 0, str_cnt = 0, mk, fk;
    exp_t m_q[$], f_q[$], me, fe;

    assign scl_pin_val = scl_t & ~hold_low;
    assign f_pin       = f_scl_t;

    i2c_scl_clkgen #(.CLK_FREQ_HZ(100_000_000), .SCL_FREQ_HZ(100_000), .STRETCH_TIMEOUT_CYC(100)) u_dut (
        .CLK(CLK), .reset(reset), .clkgen_rst(clkgen_rst), .scl_pin_val(scl_pin_val),
        .scl_t(scl_t), .fall_tick(fall_tick), .data_tick(data_tick), .rise_tick(rise_tick),
        .sample_tick(sample_tick), .stretching(stretching), .running(running),
        .stretch_timeout(stretch_timeout)
    );

    i2c_scl_clkgen #(.CLK_FREQ_HZ(800_000), .SCL_FREQ_HZ(100_000), .STRETCH_TIMEOUT_CYC(100)) u_fast (
        .CLK(CLK), .reset(reset), .clkgen_rst(f_crst), .scl_pin_val(f_pin),
        .scl_t(f_scl_t), .fall_tick(f_fall), .data_tick(f_data), .rise_tick(f_rise),
        .sample_tick(f_sample), .stretching(f_str), .running(f_run), .stretch_timeout(f_to)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic int tick_code(input logic f, input logic d, input logic r, input logic s);
        case ({f, d, r, s})
            4'b0000: return 0;
            4'b1000: return 1;
            4'b0100: return 2;
            4'b0010: return 3;
            4'b0001: return 4;
            default: return 7;
        endcase
    endfunction

    // Kinds: 1 fall, 2 data, 3 rise, 4 sample, 7 more than one tick at once.
    always @(negedge CLK) begin
        mk = tick_code(fall_tick, data_tick, rise_tick, sample_tick);
        fk = tick_code(f_fall, f_data, f_rise, f_sample);
        if (stretching === 1'b1) str_cnt++;
        if (mk != 0) begin
            checks++;
            if (m_q.size() == 0) begin
                errors++;
                $display("FAIL tick_unexpected got kind %0d at cycle %0d want none", mk, cyc);
            end else begin
                me = m_q.pop_front();
                if (mk != me.kind || cyc != me.cyc) begin
                    errors++;
                    $display("FAIL tick got kind %0d at cycle %0d want kind %0d at cycle %0d", mk, cyc, me.kind, me.cyc);
                end
            end
        end
        if (fk != 0) begin
            checks++;
            if (f_q.size() == 0) begin
                errors++;
                $display("FAIL fast_tick_unexpected got kind %0d at cycle %0d want none", fk, cyc);
            end else begin
                fe = f_q.pop_front();
                if (fk != fe.kind || cyc != fe.cyc) begin
                    errors++;
                    $display("FAIL fast_tick got kind %0d at cycle %0d want kind %0d at cycle %0d", fk, cyc, fe.kind, fe.cyc);
                end
            end
        end
    end

    task automatic push(input bit fast, input int kind, input int c);
        exp_t e;
        e.kind = kind;
        e.cyc  = c;
        if (fast) f_q.push_back(e);
        else m_q.push_back(e);
    endtask

    // Unstretched frame from HOLD entry b: fall b+2q, data b+3q, release b+4q, rise +3, sample +q.
    task automatic push_seq(input bit fast, input int b, input int q, input int n);
        for (int i = 0; i < n; i++) begin
            push(fast, 1, b + i * (4 * q + 3) + 2 * q);
            push(fast, 2, b + i * (4 * q + 3) + 3 * q);
            push(fast, 3, b + i * (4 * q + 3) + 4 * q + 3);
            push(fast, 4, b + i * (4 * q + 3) + 5 * q + 3);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge CLK);
    endtask

    task automatic drain_stop(input bit fast, input int limit);
        for (int i = 0; i < limit && (fast ? f_q.size() : m_q.size()) != 0; i++) begin
            @(negedge CLK);
            #1;
        end
        if (fast) f_crst = 1'b1;
        else clkgen_rst = 1'b1;
    endtask

    task automatic start_main(output int b);
        @(negedge CLK);
        clkgen_rst = 1'b1;
        @(negedge CLK);
        clkgen_rst = 1'b0;
        b = cyc + 1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        checks++;
        if (scl_t !== 1'b1 || running !== 1'b0 || stretching !== 1'b0 || stretch_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs scl_t=%b running=%b stretching=%b timeout=%b want 1 0 0 0", scl_t, running, stretching, stretch_timeout);
        end
        checks++;
        if ({fall_tick, data_tick, rise_tick, sample_tick} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ticks got %b want 0000", {fall_tick, data_tick, rise_tick, sample_tick});
        end
        reset = 1'b0;
        repeat (5) @(negedge CLK);
        checks++;
        if (scl_t !== 1'b1 || running !== 1'b0 || f_scl_t !== 1'b1 || f_run !== 1'b0) begin
            errors++;
            $display("FAIL held_idle scl_t=%b running=%b f_scl_t=%b f_run=%b want 1 0 1 0", scl_t, running, f_scl_t, f_run);
        end
    endtask

    task automatic test_basic();
        int b;
        start_main(b);
        push_seq(0, b, Q, 3);
        push(0, 1, b + 3 * P + 2 * Q);
        wait_cyc(b + 2 * Q - 1);
        checks++;
        if (scl_t !== 1'b1 || running !== 1'b1) begin
            errors++;
            $display("FAIL basic_hold scl_t=%b running=%b want 1 1", scl_t, running);
        end
        wait_cyc(b + 2 * Q);
        checks++;
        if (scl_t !== 1'b0) begin
            errors++;
            $display("FAIL basic_low scl_t=%b want 0", scl_t);
        end
        wait_cyc(b + 4 * Q);
        checks++;
        if (scl_t !== 1'b1 || stretching !== 1'b1) begin
            errors++;
            $display("FAIL basic_release scl_t=%b stretching=%b want 1 1", scl_t, stretching);
        end
        drain_stop(0, 4 * P);
        checks++;
        if (m_q.size() != 0) begin
            errors++;
            $display("FAIL basic_drain left %0d want 0", m_q.size());
        end
    endtask

    task automatic test_abort();
        int b;
        start_main(b);
        push(0, 1, b + 2 * Q);
        wait_cyc(b + 2 * Q + 10);
        clkgen_rst = 1'b1;
        wait_cyc(b + 2 * Q + 11);
        checks++;
        if (scl_t !== 1'b1 || running !== 1'b0 || {fall_tick, data_tick, rise_tick, sample_tick} !== 4'b0) begin
            errors++;
            $display("FAIL abort_idle scl_t=%b running=%b ticks=%b want 1 0 0000", scl_t, running, {fall_tick, data_tick, rise_tick, sample_tick});
        end
        repeat (3) @(negedge CLK);
        clkgen_rst = 1'b0;
        b = cyc + 1;
        push_seq(0, b, Q, 1);
        push(0, 1, b + P + 2 * Q);
        wait_cyc(b + 2 * Q - 1);
        checks++;
        if (scl_t !== 1'b1) begin
            errors++;
            $display("FAIL abort_rehold scl_t=%b want 1", scl_t);
        end
        drain_stop(0, 3 * P);
        checks++;
        if (m_q.size() != 0) begin
            errors++;
            $display("FAIL abort_drain left %0d want 0", m_q.size());
        end
    endtask

    task automatic test_stretch();
        int b, r, n0;
        start_main(b);
        r = b + 4 * Q;
        push(0, 1, b + 2 * Q);
        push(0, 2, b + 3 * Q);
        push(0, 3, r + 403);
        push(0, 4, r + 403 + Q);
        push(0, 1, r + 403 + 2 * Q);
        wait_cyc(r - 1);
        hold_low = 1'b1;
        n0 = str_cnt;
        while (cyc < r + 400) begin
            @(posedge CLK);
            #1;
            if (cyc == r + 200) begin
                checks++;
                if (scl_t !== 1'b1 || running !== 1'b1 || stretching !== 1'b1) begin
                    errors++;
                    $display("FAIL stretch_mid scl_t=%b running=%b stretching=%b want 1 1 1", scl_t, running, stretching);
                end
            end
        end
        hold_low = 1'b0;
        drain_stop(0, 3 * P);
        checks++;
        if (m_q.size() != 0) begin
            errors++;
            $display("FAIL stretch_drain left %0d want 0", m_q.size());
        end
        checks++;
        if (str_cnt - n0 != 402) begin
            errors++;
            $display("FAIL stretch_cycles got %0d want 402", str_cnt - n0);
        end
        checks++;
        if (stretch_timeout !== 1'b0) begin
            errors++;
            $display("FAIL stretch_no_timeout got %b want 0", stretch_timeout);
        end
    endtask

    task automatic test_timeout();
        int b, r;
        start_main(b);
        r = b + 4 * Q;
        push(0, 1, b + 2 * Q);
        push(0, 2, b + 3 * Q);
        wait_cyc(r - 1);
        hold_low = 1'b1;
        wait_cyc(r + 99);
        checks++;
        if (stretch_timeout !== 1'b0 || running !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early timeout=%b running=%b want 0 1", stretch_timeout, running);
        end
        wait_cyc(r + 100);
        checks++;
        if (stretch_timeout !== 1'b1 || scl_t !== 1'b1 || running !== 1'b0) begin
            errors++;
            $display("FAIL timeout_hit timeout=%b scl_t=%b running=%b want 1 1 0", stretch_timeout, scl_t, running);
        end
        hold_low = 1'b0;
        wait_cyc(r + 130);
        checks++;
        if (stretch_timeout !== 1'b1 || running !== 1'b0 || m_q.size() != 0) begin
            errors++;
            $display("FAIL timeout_sticky timeout=%b running=%b left=%0d want 1 0 0", stretch_timeout, running, m_q.size());
        end
        clkgen_rst = 1'b1;
        @(negedge CLK);
        checks++;
        if (stretch_timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear got %b want 0", stretch_timeout);
        end
    endtask

    task automatic test_reset_mid();
        int b;
        start_main(b);
        push_seq(0, b, Q, 1);
        wait_cyc(b + 5 * Q + 23);
        reset = 1'b1;
        @(negedge CLK);
        checks++;
        if (scl_t !== 1'b1 || running !== 1'b0 || stretching !== 1'b0 || stretch_timeout !== 1'b0 ||
            {fall_tick, data_tick, rise_tick, sample_tick} !== 4'b0) begin
            errors++;
            $display("FAIL reset_mid scl_t=%b running=%b stretching=%b ticks=%b want 1 0 0 0000", scl_t, running, stretching, {fall_tick, data_tick, rise_tick, sample_tick});
        end
        checks++;
        if (m_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_pre left %0d want 0", m_q.size());
        end
        reset = 1'b0;
        b = cyc + 1;
        push_seq(0, b, Q, 2);
        push(0, 1, b + 2 * P + 2 * Q);
        drain_stop(0, 4 * P);
        checks++;
        if (m_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_drain left %0d want 0", m_q.size());
        end
    endtask

    task automatic test_min_quarter();
        int b;
        @(negedge CLK);
        f_crst = 1'b0;
        b = cyc + 1;
        push_seq(1, b, FQ, 3);
        push(1, 1, b + 3 * 11 + 2 * FQ);
        drain_stop(1, 100);
        checks++;
        if (f_q.size() != 0) begin
            errors++;
            $display("FAIL min_quarter_drain left %0d want 0", f_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_abort();
`ifdef I2C_STRETCH_TIMEOUT_EN
        test_timeout();
`else
        test_stretch();
`endif
        test_reset_mid();
        test_min_quarter();
        repeat (5) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog at cycle %0d want finish before it", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
